// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl
// Frame parser for bytes coming out of a UART receiver.
// Frame format: SYNC_BYTE, LEN (1..MAX_LEN), LEN payload bytes, CHK.
// CHK is the 8-bit modulo-256 sum of LEN and every payload byte.
// A frame that passes the check is held in a small buffer. The consumer
// drains it one byte at a time with i_Rd_En, and o_Rd_Data shows the byte
// at the read pointer without a clock delay.
// Length, checksum and idle-timeout errors drop the frame and produce a
// one-cycle pulse. A byte that arrives while a frame is still held is
// dropped and produces an overrun pulse.

module uart_rx_frame_ctrl #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_CLKS = 4340
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  input  logic       i_Rd_En,
  output logic       o_Frame_Valid,
  output logic [4:0] o_Frame_Len,
  output logic [7:0] o_Rd_Data,
  output logic       o_Err_Chk,
  output logic       o_Err_Len,
  output logic       o_Err_Timeout,
  output logic       o_Overrun,
  output logic       o_Busy
);

  // The idle counter runs from 0 up to TIMEOUT_CLKS-1, so clog2 bits are enough.
  // The 1-bit floor only covers degenerate tiny timeouts.
  localparam int CNT_W = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CLKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHK,
    ST_DELIVER
  } state_t;

  state_t           r_state;
  logic [4:0]       r_len;
  logic [7:0]       r_sum;
  logic [4:0]       r_wr_ptr;
  logic [4:0]       r_rd_ptr;
  logic [CNT_W-1:0] r_idle_cnt;
  logic             r_frame_valid;
  logic [4:0]       r_frame_len;
  logic             r_err_chk;
  logic             r_err_len;
  logic             r_err_timeout;
  logic             r_overrun;
  logic             r_busy;

  // The buffer has the full 5-bit pointer depth, so any pointer value is a
  // legal index. Only the first MAX_LEN entries are ever written.
  logic [7:0]       r_buf [0:31];

  logic             w_timeout;
  logic             w_len_bad;
  logic             w_last_wr;
  logic             w_last_rd;

  assign w_timeout = (r_idle_cnt == CNT_LAST);
  assign w_len_bad = (i_RX_Byte == 8'd0) || (i_RX_Byte > MAX_LEN_B);
  assign w_last_wr = (r_wr_ptr == (r_len - 5'd1));
  assign w_last_rd = (r_rd_ptr == (r_len - 5'd1));

  // Payload storage. There is no reset because stale contents are never read.
  always_ff @(posedge i_Clock) begin
    if (r_state == ST_PAYLOAD && i_RX_DV) begin
      r_buf[r_wr_ptr] <= i_RX_Byte;
    end
  end

  // Frame FSM. It also drives all registered outputs and the error pulses.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_state       <= ST_IDLE;
      r_len         <= 5'd0;
      r_sum         <= 8'd0;
      r_wr_ptr      <= 5'd0;
      r_rd_ptr      <= 5'd0;
      r_idle_cnt    <= '0;
      r_frame_valid <= 1'b0;
      r_frame_len   <= 5'd0;
      r_err_chk     <= 1'b0;
      r_err_len     <= 1'b0;
      r_err_timeout <= 1'b0;
      r_overrun     <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      // Each pulse lasts one cycle unless a branch below sets it again.
      r_err_chk     <= 1'b0;
      r_err_len     <= 1'b0;
      r_err_timeout <= 1'b0;
      r_overrun     <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          r_idle_cnt <= '0;
          if (i_RX_DV && (i_RX_Byte == SYNC_BYTE)) begin
            r_state <= ST_LEN;
            r_busy  <= 1'b1;
          end
        end

        ST_LEN: begin
          if (i_RX_DV) begin
            r_idle_cnt <= '0;
            if (w_len_bad) begin
              r_err_len <= 1'b1;
              r_state   <= ST_IDLE;
              r_busy    <= 1'b0;
              r_wr_ptr  <= 5'd0;
              r_rd_ptr  <= 5'd0;
              r_sum     <= 8'd0;
            end else begin
              r_len    <= i_RX_Byte[4:0];
              r_sum    <= i_RX_Byte;
              r_wr_ptr <= 5'd0;
              r_state  <= ST_PAYLOAD;
            end
          end else if (w_timeout) begin
            r_err_timeout <= 1'b1;
            r_state       <= ST_IDLE;
            r_busy        <= 1'b0;
            r_idle_cnt    <= '0;
            r_wr_ptr      <= 5'd0;
            r_rd_ptr      <= 5'd0;
            r_sum         <= 8'd0;
          end else begin
            r_idle_cnt <= r_idle_cnt + CNT_ONE;
          end
        end

        ST_PAYLOAD: begin
          // A byte equal to SYNC_BYTE is stored here like any other data byte.
          if (i_RX_DV) begin
            r_idle_cnt <= '0;
            r_sum      <= r_sum + i_RX_Byte;
            r_wr_ptr   <= r_wr_ptr + 5'd1;
            if (w_last_wr) begin
              r_state <= ST_CHK;
            end
          end else if (w_timeout) begin
            r_err_timeout <= 1'b1;
            r_state       <= ST_IDLE;
            r_busy        <= 1'b0;
            r_idle_cnt    <= '0;
            r_wr_ptr      <= 5'd0;
            r_rd_ptr      <= 5'd0;
            r_sum         <= 8'd0;
          end else begin
            r_idle_cnt <= r_idle_cnt + CNT_ONE;
          end
        end

        ST_CHK: begin
          if (i_RX_DV) begin
            r_idle_cnt <= '0;
            if (i_RX_Byte == r_sum) begin
              r_state       <= ST_DELIVER;
              r_frame_valid <= 1'b1;
              r_frame_len   <= r_len;
              r_rd_ptr      <= 5'd0;
            end else begin
              r_err_chk <= 1'b1;
              r_state   <= ST_IDLE;
              r_busy    <= 1'b0;
              r_wr_ptr  <= 5'd0;
              r_rd_ptr  <= 5'd0;
              r_sum     <= 8'd0;
            end
          end else if (w_timeout) begin
            r_err_timeout <= 1'b1;
            r_state       <= ST_IDLE;
            r_busy        <= 1'b0;
            r_idle_cnt    <= '0;
            r_wr_ptr      <= 5'd0;
            r_rd_ptr      <= 5'd0;
            r_sum         <= 8'd0;
          end else begin
            r_idle_cnt <= r_idle_cnt + CNT_ONE;
          end
        end

        ST_DELIVER: begin
          r_idle_cnt <= '0;
          // Incoming bytes are dropped while a frame is held, including on
          // the cycle of the final read.
          if (i_RX_DV) begin
            r_overrun <= 1'b1;
          end
          if (i_Rd_En) begin
            if (w_last_rd) begin
              r_frame_valid <= 1'b0;
              r_frame_len   <= 5'd0;
              r_wr_ptr      <= 5'd0;
              r_rd_ptr      <= 5'd0;
              r_sum         <= 8'd0;
              r_state       <= ST_IDLE;
              r_busy        <= 1'b0;
            end else begin
              r_rd_ptr <= r_rd_ptr + 5'd1;
            end
          end
        end

        default: begin
          r_state       <= ST_IDLE;
          r_busy        <= 1'b0;
          r_idle_cnt    <= '0;
          r_wr_ptr      <= 5'd0;
          r_rd_ptr      <= 5'd0;
          r_sum         <= 8'd0;
          r_frame_valid <= 1'b0;
          r_frame_len   <= 5'd0;
        end
      endcase
    end
  end

  assign o_Frame_Valid = r_frame_valid;
  assign o_Frame_Len   = r_frame_len;
  assign o_Rd_Data     = r_buf[r_rd_ptr];
  assign o_Err_Chk     = r_err_chk;
  assign o_Err_Len     = r_err_len;
  assign o_Err_Timeout = r_err_timeout;
  assign o_Overrun     = r_overrun;
  assign o_Busy        = r_busy;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed testbench for uart_rx_frame_ctrl with hand-computed expected values.
// Inputs change and outputs are sampled 1 ns after each rising clock edge.

module tb_uart_rx_frame_ctrl;

  localparam int TO_CLKS = 4340;

  logic       i_Clock;
  logic       i_Rst_n;
  logic       i_RX_DV;
  logic [7:0] i_RX_Byte;
  logic       i_Rd_En;
  logic       o_Frame_Valid;
  logic [4:0] o_Frame_Len;
  logic [7:0] o_Rd_Data;
  logic       o_Err_Chk;
  logic       o_Err_Len;
  logic       o_Err_Timeout;
  logic       o_Overrun;
  logic       o_Busy;

  int n_checks;
  int n_fail;

  uart_rx_frame_ctrl #(
    .SYNC_BYTE   (8'hA5),
    .MAX_LEN     (16),
    .TIMEOUT_CLKS(TO_CLKS)
  ) dut (
    .i_Clock      (i_Clock),
    .i_Rst_n      (i_Rst_n),
    .i_RX_DV      (i_RX_DV),
    .i_RX_Byte    (i_RX_Byte),
    .i_Rd_En      (i_Rd_En),
    .o_Frame_Valid(o_Frame_Valid),
    .o_Frame_Len  (o_Frame_Len),
    .o_Rd_Data    (o_Rd_Data),
    .o_Err_Chk    (o_Err_Chk),
    .o_Err_Len    (o_Err_Len),
    .o_Err_Timeout(o_Err_Timeout),
    .o_Overrun    (o_Overrun),
    .o_Busy       (o_Busy)
  );

  initial i_Clock = 1'b0;
  always #5 i_Clock = ~i_Clock;

  // Stops a hung run while still reporting a failure line.
  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge i_Clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_RX_DV   = 1'b1;
    i_RX_Byte = b;
    tick();
    i_RX_DV   = 1'b0;
    i_RX_Byte = 8'h00;
  endtask

  task automatic read_byte();
    i_Rd_En = 1'b1;
    tick();
    i_Rd_En = 1'b0;
  endtask

  task automatic check_idle_outs(input string tag);
    check_val({tag, "_valid"}, 32'(o_Frame_Valid), 32'd0);
    check_val({tag, "_len"},   32'(o_Frame_Len),   32'd0);
    check_val({tag, "_busy"},  32'(o_Busy),        32'd0);
    check_val({tag, "_errs"},  32'({o_Err_Chk, o_Err_Len, o_Err_Timeout, o_Overrun}), 32'd0);
  endtask

  int to_seen;
  int to_at;

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    i_Rst_n   = 1'b0;
    i_RX_DV   = 1'b0;
    i_RX_Byte = 8'h00;
    i_Rd_En   = 1'b0;
    #1;
    check_idle_outs("rst");
    tick();
    tick();
    #2 i_Rst_n = 1'b1;
    tick();

    // Basic frame. An i_Rd_En during PAYLOAD must be ignored.
    send_byte(8'hA5);
    check_val("f1_busy_len", 32'(o_Busy), 32'd1);
    send_byte(8'h03);
    send_byte(8'h11);
    read_byte();
    send_byte(8'h22);
    send_byte(8'h33);
    check_val("f1_valid_pre", 32'(o_Frame_Valid), 32'd0);
    send_byte(8'h69);
    check_val("f1_valid", 32'(o_Frame_Valid), 32'd1);
    check_val("f1_len",   32'(o_Frame_Len),   32'd3);
    check_val("f1_d0",    32'(o_Rd_Data),     32'h11);
    read_byte();
    check_val("f1_d1",    32'(o_Rd_Data),     32'h22);
    read_byte();
    check_val("f1_d2",    32'(o_Rd_Data),     32'h33);
    check_val("f1_valid_hold", 32'(o_Frame_Valid), 32'd1);
    read_byte();
    check_val("f1_valid_end", 32'(o_Frame_Valid), 32'd0);
    check_val("f1_busy_end",  32'(o_Busy),        32'd0);

    // Checksum error, then a good frame.
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h6A);
    check_val("chk_err",   32'(o_Err_Chk),     32'd1);
    check_val("chk_valid", 32'(o_Frame_Valid), 32'd0);
    check_val("chk_busy",  32'(o_Busy),        32'd0);
    tick();
    check_val("chk_err_off", 32'(o_Err_Chk), 32'd0);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h05); send_byte(8'h06);
    check_val("f2_valid", 32'(o_Frame_Valid), 32'd1);
    check_val("f2_len",   32'(o_Frame_Len),   32'd1);
    check_val("f2_d0",    32'(o_Rd_Data),     32'h05);
    read_byte();
    check_val("f2_valid_end", 32'(o_Frame_Valid), 32'd0);

    // Length errors: zero and MAX_LEN+1.
    send_byte(8'hA5); send_byte(8'h00);
    check_val("len0_err",  32'(o_Err_Len), 32'd1);
    check_val("len0_busy", 32'(o_Busy),    32'd0);
    tick();
    check_val("len0_err_off", 32'(o_Err_Len), 32'd0);
    send_byte(8'hA5); send_byte(8'h11);
    check_val("len17_err",  32'(o_Err_Len), 32'd1);
    check_val("len17_busy", 32'(o_Busy),    32'd0);
    tick();
    check_val("len17_err_off", 32'(o_Err_Len), 32'd0);

    // A stray byte is ignored, and SYNC_BYTE values inside a frame are data.
    send_byte(8'h42);
    check_val("stray_busy", 32'(o_Busy), 32'd0);
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'hA5); send_byte(8'hA5); send_byte(8'h4C);
    check_val("f3_valid", 32'(o_Frame_Valid), 32'd1);
    check_val("f3_len",   32'(o_Frame_Len),   32'd2);
    check_val("f3_d0",    32'(o_Rd_Data),     32'hA5);
    read_byte();
    check_val("f3_d1",    32'(o_Rd_Data),     32'hA5);
    read_byte();
    check_val("f3_valid_end", 32'(o_Frame_Valid), 32'd0);

    // A gap of TIMEOUT_CLKS-2 idle clocks does not time out.
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    to_seen = 0;
    for (int k = 0; k < TO_CLKS - 2; k++) begin
      tick();
      if (o_Err_Timeout) to_seen++;
    end
    check_val("gap_no_timeout", 32'(to_seen), 32'd0);
    check_val("gap_busy",       32'(o_Busy),  32'd1);
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h69);
    check_val("f4_valid", 32'(o_Frame_Valid), 32'd1);
    check_val("f4_d0",    32'(o_Rd_Data),     32'h11);
    read_byte(); read_byte(); read_byte();
    check_val("f4_valid_end", 32'(o_Frame_Valid), 32'd0);

    // Silence for TIMEOUT_CLKS: one pulse, after the last idle clock.
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    to_seen = 0;
    to_at   = 0;
    for (int k = 1; k <= TO_CLKS + 5; k++) begin
      tick();
      if (o_Err_Timeout) begin
        to_seen++;
        to_at = k;
        check_val("to_busy", 32'(o_Busy), 32'd0);
      end
    end
    check_val("to_count", 32'(to_seen), 32'd1);
    check_val("to_cycle", 32'(to_at),   32'(TO_CLKS));

    // Overrun while a frame is held, including on the final-read cycle.
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'h67);
    check_val("f5_valid", 32'(o_Frame_Valid), 32'd1);
    send_byte(8'hA5);
    check_val("ovr1",       32'(o_Overrun),     32'd1);
    check_val("ovr1_valid", 32'(o_Frame_Valid), 32'd1);
    check_val("ovr1_len",   32'(o_Frame_Len),   32'd2);
    check_val("ovr1_d0",    32'(o_Rd_Data),     32'hAA);
    tick();
    check_val("ovr1_off",   32'(o_Overrun),     32'd0);
    read_byte();
    check_val("f5_d1",      32'(o_Rd_Data),     32'hBB);
    i_Rd_En   = 1'b1;
    i_RX_DV   = 1'b1;
    i_RX_Byte = 8'hA5;
    tick();
    i_Rd_En   = 1'b0;
    i_RX_DV   = 1'b0;
    i_RX_Byte = 8'h00;
    check_val("ovr2",       32'(o_Overrun),     32'd1);
    check_val("ovr2_valid", 32'(o_Frame_Valid), 32'd0);
    check_val("ovr2_busy",  32'(o_Busy),        32'd0);
    send_byte(8'h01);
    check_val("ovr2_not_parsed", 32'(o_Busy), 32'd0);

    // Asynchronous reset in PAYLOAD, then a clean frame.
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    #2 i_Rst_n = 1'b0;
    #1;
    check_idle_outs("rst_pl");
    #2 i_Rst_n = 1'b1;
    tick();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h07); send_byte(8'h08);
    check_val("f6_valid", 32'(o_Frame_Valid), 32'd1);
    check_val("f6_d0",    32'(o_Rd_Data),     32'h07);

    // Asynchronous reset in DELIVER, then a clean frame.
    #2 i_Rst_n = 1'b0;
    #1;
    check_idle_outs("rst_dl");
    #2 i_Rst_n = 1'b1;
    tick();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h01); send_byte(8'h02); send_byte(8'h05);
    check_val("f7_valid", 32'(o_Frame_Valid), 32'd1);
    check_val("f7_len",   32'(o_Frame_Len),   32'd2);
    check_val("f7_d0",    32'(o_Rd_Data),     32'h01);
    read_byte();
    check_val("f7_d1",    32'(o_Rd_Data),     32'h02);
    read_byte();
    check_val("f7_valid_end", 32'(o_Frame_Valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_ctrl.md
UART_RX_FRAME_CTRL -- requirements
Module: uart_rx_frame_ctrl

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-002 SHALL have parameter MAX_LEN, default 16, maximum payload bytes per frame, legal range 1..31.
REQ-003 SHALL have parameter TIMEOUT_CLKS, default 4340, idle clocks allowed between bytes inside a frame (20 bit times at 217 clocks/bit).
REQ-004 SHALL have i_Clock  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have i_Rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have i_RX_DV  input  1  one-cycle strobe from the UART receiver marking a valid byte.
REQ-007 SHALL have i_RX_Byte  input  8  received byte, valid when i_RX_DV=1.
REQ-008 SHALL have i_Rd_En  input  1  consumer pops one payload byte.
REQ-009 SHALL have o_Frame_Valid  output  1  complete, checked frame held for reading.
REQ-010 SHALL have o_Frame_Len  output  5  payload length of the held frame.
REQ-011 SHALL have o_Rd_Data  output  8  payload byte at the current read pointer, combinational from the buffer.
REQ-012 SHALL have o_Err_Chk, o_Err_Len, o_Err_Timeout, o_Overrun  output  1 each  one-cycle error pulses.
REQ-013 SHALL have o_Busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement states IDLE, LEN, PAYLOAD, CHK, DELIVER.
REQ-015 IDLE: i_RX_DV with i_RX_Byte==SYNC_BYTE SHALL go to LEN; other bytes SHALL be ignored silently.
REQ-016 LEN: on i_RX_DV, byte 0 or byte >MAX_LEN SHALL pulse o_Err_Len and return to IDLE; otherwise SHALL store the length, seed the 8-bit sum with it, and go to PAYLOAD.
REQ-017 PAYLOAD: each i_RX_DV SHALL write the byte to buffer[wr_ptr], add it to the sum modulo 256, and increment wr_ptr; after the stored-length-th byte SHALL go to CHK.
REQ-018 SYNC_BYTE values inside LEN/PAYLOAD/CHK SHALL be treated as ordinary data; there is no resynchronisation.
REQ-019 CHK: on i_RX_DV, byte==sum SHALL go to DELIVER with o_Frame_Valid=1 on the next cycle; mismatch SHALL pulse o_Err_Chk and return to IDLE.
REQ-020 In LEN, PAYLOAD and CHK, an idle counter SHALL clear on every i_RX_DV and on state entry; reaching TIMEOUT_CLKS-1 without a byte SHALL pulse o_Err_Timeout and return to IDLE.
REQ-021 The counter width SHALL be clog2(TIMEOUT_CLKS); the counter SHALL hold at zero in IDLE and DELIVER.
REQ-022 DELIVER: o_Frame_Valid=1, o_Frame_Len=stored length, o_Rd_Data=buffer[rd_ptr] with rd_ptr starting at 0.
REQ-023 i_Rd_En in DELIVER SHALL increment rd_ptr on the next edge; i_Rd_En with rd_ptr==len-1 SHALL deassert o_Frame_Valid, clear both pointers, and return to IDLE on the next edge.
REQ-024 i_Rd_En outside DELIVER SHALL be ignored.
REQ-025 i_RX_DV in DELIVER, including the cycle of the final read, SHALL drop the byte and pulse o_Overrun the next cycle.
REQ-026 Any abort to IDLE SHALL clear wr_ptr, rd_ptr and the sum; buffer contents need not be cleared.
REQ-027 Every error pulse SHALL be exactly one cycle, registered, and asserted the cycle after the causing i_RX_DV or timeout.

Reset
REQ-028 i_Rst_n=0 SHALL immediately force state IDLE, clear pointers, sum and idle counter, and drive o_Frame_Valid, o_Frame_Len, o_Busy and all error pulses to 0, regardless of operation in progress.
REQ-029 o_Rd_Data SHALL be don't-care while o_Frame_Valid=0.

Verification
REQ-030 Bytes A5 03 11 22 33 69 -> o_Frame_Valid=1, o_Frame_Len=3; three i_Rd_En reads return 11, 22, 33; o_Frame_Valid=0 after the third read.
REQ-031 Bytes A5 03 11 22 33 6A -> one o_Err_Chk pulse, o_Frame_Valid stays 0; the following A5 01 05 06 is delivered correctly.
REQ-032 Bytes A5 00 and A5 11 -> one o_Err_Len pulse each, returning to IDLE; bytes 42 A5 02 A5 A5 4C -> frame with payload A5 A5, checksum 0x4C accepted.
REQ-033 A5 03 11 then silence for TIMEOUT_CLKS -> o_Err_Timeout pulse, o_Busy=0; A5 03 11 with the next byte at TIMEOUT_CLKS-2 idle clocks -> no timeout.
REQ-034 Frame held with a byte arriving in DELIVER, including the final-read cycle -> o_Overrun pulse, held frame unchanged, byte not parsed.
REQ-035 i_Rst_n low mid-PAYLOAD and in DELIVER -> all outputs 0 asynchronously; the next full frame after release is delivered correctly.
